// File: rtl/sram_bist_ctrl_if.sv
// rtl/sram_bist_ctrl_if.sv - SRAM port bundle between the BIST master and the SRAM instance
interface sram_bist_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              mem_wr;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_add;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;

    modport master (
        output mem_wr,
        output mem_rd,
        output mem_add,
        output mem_data_in,
        input  mem_data_out
    );

    modport slave (
        input  mem_wr,
        input  mem_rd,
        input  mem_add,
        input  mem_data_in,
        output mem_data_out
    );
endinterface

// File: rtl/sram_bist_ctrl.sv
// rtl/sram_bist_ctrl.sv - SRAM write/read-back self-test master
// SRAM_BIST_MARCH_EN adds inverse-pattern write and read phases after the plain read phase.
module sram_bist_ctrl #(
    parameter int                DATA_W = 8,
    parameter int                ADDR_W = 3,
    parameter int                RD_LAT = 1,
    parameter logic [DATA_W-1:0] SEED   = 8'hAA
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ADDR_W-1:0]   fail_addr,
    output logic [ADDR_W+1:0]   err_cnt,
    sram_bist_ctrl_if.master    mem
);

`ifdef SRAM_BIST_MARCH_EN
    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_READ, S_WRITE_INV, S_READ_INV, S_DRAIN, S_DONE
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE
    } state_t;
`endif

    localparam logic [ADDR_W-1:0] LAST = '1;

    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
        return SEED + DATA_W'(a);
    endfunction

    state_t              state;
    state_t              state_nx;
    logic                wr_nx;
    logic                rd_nx;
    logic [ADDR_W-1:0]   add_nx;
    logic [DATA_W-1:0]   din_nx;
    logic                busy_nx;
    logic                done_nx;
    logic                accept;
    logic [ADDR_W-1:0]   addr_inc;
    logic [DATA_W-1:0]   rd_exp;
    logic                mismatch;

    // Expected-value pipeline: entry pushed on the edge the SRAM samples a read,
    // compared RD_LAT edges later when the read data is valid.
    logic [RD_LAT-1:0]   pipe_v;
    logic [ADDR_W-1:0]   pipe_a [RD_LAT];
    logic [DATA_W-1:0]   pipe_d [RD_LAT];

    // mem_add doubles as the phase address counter; it holds between accesses.
    assign addr_inc = mem.mem_add + 1'b1;
    assign mismatch = pipe_v[RD_LAT-1] && (mem.mem_data_out != pipe_d[RD_LAT-1]);

    always_comb begin
        rd_exp = pattern(mem.mem_add);
`ifdef SRAM_BIST_MARCH_EN
        if (state == S_READ_INV) rd_exp = ~rd_exp;
`endif
    end

    always_comb begin
        state_nx = state;
        wr_nx    = 1'b0;
        rd_nx    = 1'b0;
        add_nx   = mem.mem_add;
        din_nx   = mem.mem_data_in;
        busy_nx  = busy;
        done_nx  = 1'b0;
        accept   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_WRITE;
                    wr_nx    = 1'b1;
                    add_nx   = '0;
                    din_nx   = pattern('0);
                    busy_nx  = 1'b1;
                    accept   = 1'b1;
                end
            end
            S_WRITE: begin
                if (mem.mem_add == LAST) begin
                    state_nx = S_READ;
                    rd_nx    = 1'b1;
                    add_nx   = '0;
                end else begin
                    wr_nx  = 1'b1;
                    add_nx = addr_inc;
                    din_nx = pattern(addr_inc);
                end
            end
            S_READ: begin
                if (mem.mem_add == LAST) begin
`ifdef SRAM_BIST_MARCH_EN
                    state_nx = S_WRITE_INV;
                    wr_nx    = 1'b1;
                    add_nx   = '0;
                    din_nx   = ~pattern('0);
`else
                    state_nx = S_DRAIN;
`endif
                end else begin
                    rd_nx  = 1'b1;
                    add_nx = addr_inc;
                end
            end
`ifdef SRAM_BIST_MARCH_EN
            S_WRITE_INV: begin
                if (mem.mem_add == LAST) begin
                    state_nx = S_READ_INV;
                    rd_nx    = 1'b1;
                    add_nx   = '0;
                end else begin
                    wr_nx  = 1'b1;
                    add_nx = addr_inc;
                    din_nx = ~pattern(addr_inc);
                end
            end
            S_READ_INV: begin
                if (mem.mem_add == LAST) begin
                    state_nx = S_DRAIN;
                end else begin
                    rd_nx  = 1'b1;
                    add_nx = addr_inc;
                end
            end
`endif
            S_DRAIN: begin
                if (pipe_v == '0) begin
                    state_nx = S_DONE;
                    done_nx  = 1'b1;
                    busy_nx  = 1'b0;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            mem.mem_wr      <= 1'b0;
            mem.mem_rd      <= 1'b0;
            mem.mem_add     <= '0;
            mem.mem_data_in <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            fail_addr       <= '0;
            err_cnt         <= '0;
            pipe_v          <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_a[i] <= '0;
                pipe_d[i] <= '0;
            end
        end else begin
            state           <= state_nx;
            mem.mem_wr      <= wr_nx;
            mem.mem_rd      <= rd_nx;
            mem.mem_add     <= add_nx;
            mem.mem_data_in <= din_nx;
            busy            <= busy_nx;
            done            <= done_nx;

            pipe_v[0] <= mem.mem_rd;
            pipe_a[0] <= mem.mem_add;
            pipe_d[0] <= rd_exp;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_a[i] <= pipe_a[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end

            if (accept) begin
                pass      <= 1'b0;
                err_cnt   <= '0;
                fail_addr <= '0;
            end else begin
                if (done_nx) pass <= (err_cnt == '0);
                if (mismatch) begin
                    if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                    if (err_cnt == '0) fail_addr <= pipe_a[RD_LAT-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_bist_ctrl.sv
// tb/tb_sram_bist_ctrl.sv - scoreboard bench for sram_bist_ctrl with a fault-injecting SRAM model
module tb_sram_bist_ctrl;
    localparam int         DATA_W = 8;
    localparam int         ADDR_W = 3;
    localparam int         RD_LAT = 1;
    localparam int         DEPTH  = 8;
    localparam logic [7:0] SEED   = 8'hAA;
`ifdef SRAM_BIST_MARCH_EN
    localparam int NPH = 2;
`else
    localparam int NPH = 1;
`endif
    localparam int LAT = 2 * NPH * DEPTH + RD_LAT + 1;

    typedef struct {
        logic       pass;
        logic [4:0] err;
        logic [2:0] fa;
        int         done_cyc;
    } exp_t;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] fail_addr;
    logic [4:0] err_cnt;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   wcount = 0;
    int   rcount = 0;
    exp_t q [$];

    logic [7:0] sram  [DEPTH];
    logic [7:0] and_m [DEPTH];
    logic [7:0] or_m  [DEPTH];

    sram_bist_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    sram_bist_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .pass(pass), .fail_addr(fail_addr), .err_cnt(err_cnt), .mem(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous SRAM with per-address stuck-at faults applied to stored data
    always @(posedge clk) begin
        if (bus.mem_wr) sram[bus.mem_add] <= (bus.mem_data_in & and_m[bus.mem_add]) | or_m[bus.mem_add];
        if (bus.mem_rd) bus.mem_data_out <= sram[bus.mem_add];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_faults();
        for (int a = 0; a < DEPTH; a++) begin
            and_m[a] = 8'hFF;
            or_m[a]  = 8'h00;
        end
    endtask

    task automatic set_sa(input int a, input int b, input bit v);
        and_m[a][b] = v;
        or_m[a][b]  = v;
    endtask

    // Expected outcome from the fault map: every phase writes then reads all addresses in order
    function automatic exp_t model();
        exp_t       e;
        int         errs;
        int         first;
        logic [7:0] w;
        logic [7:0] r;
        errs  = 0;
        first = -1;
        for (int ph = 0; ph < NPH; ph++) begin
            for (int a = 0; a < DEPTH; a++) begin
                w = SEED + 8'(a);
                if (ph == 1) w = ~w;
                r = (w & and_m[a]) | or_m[a];
                if (r != w) begin
                    errs++;
                    if (first < 0) first = a;
                end
            end
        end
        e.pass     = (errs == 0);
        e.err      = (errs > 31) ? 5'd31 : 5'(errs);
        e.fa       = (first < 0) ? 3'd0 : 3'(first);
        e.done_cyc = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t       e;
        logic [7:0] wexp;
        if (!rst) begin
            chk("wr_rd_exclusive", 32'(bus.mem_wr & bus.mem_rd), 0);
            if (bus.mem_wr) begin
                wexp = SEED + 8'(wcount % DEPTH);
                if (wcount >= DEPTH) wexp = ~wexp;
                chk("wr_addr", 32'(bus.mem_add), wcount % DEPTH);
                chk("wr_data", 32'(bus.mem_data_in), 32'(wexp));
                wcount++;
            end
            if (bus.mem_rd) begin
                chk("rd_addr", 32'(bus.mem_add), rcount % DEPTH);
                rcount++;
            end
        end
        if (done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done at cycle %0d, required no done", cyc);
            end else begin
                e = q.pop_front();
                chk("done_cycle", cyc, e.done_cyc);
                chk("pass", 32'(pass), 32'(e.pass));
                chk("err_cnt", 32'(err_cnt), 32'(e.err));
                chk("fail_addr", 32'(fail_addr), 32'(e.fa));
                chk("busy_at_done", 32'(busy), 0);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_pass"}, 32'(pass), 0);
        chk({tag, "_fail_addr"}, 32'(fail_addr), 0);
        chk({tag, "_err_cnt"}, 32'(err_cnt), 0);
        chk({tag, "_mem_wr"}, 32'(bus.mem_wr), 0);
        chk({tag, "_mem_rd"}, 32'(bus.mem_rd), 0);
        chk({tag, "_mem_add"}, 32'(bus.mem_add), 0);
        chk({tag, "_mem_data_in"}, 32'(bus.mem_data_in), 0);
    endtask

    task automatic run_one(input bit extra);
        exp_t e;
        int   n;
        e = model();
        @(negedge clk);
        e.done_cyc = cyc + 1 + LAT;
        q.push_back(e);
        wcount = 0;
        rcount = 0;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 1);
        if (extra) begin
            repeat (3) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        n = 0;
        while (q.size() != 0 && n < 4 * LAT) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done within %0d cycles, required done at cycle %0d", 4 * LAT, e.done_cyc);
            q.delete();
        end
        @(negedge clk);
        chk("pass_hold", 32'(pass), 32'(e.pass));
        chk("busy_idle", 32'(busy), 0);
    endtask

    initial begin
        int n;
        int nf;
        int a;
        int b;
        clear_faults();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        clear_faults();
        run_one(1'b0);

        clear_faults();
        set_sa(3, 0, 1'b0);
        run_one(1'b0);

        clear_faults();
        set_sa(5, 0, 1'b0);
        set_sa(2, 0, 1'b1);
        run_one(1'b0);

        clear_faults();
        run_one(1'b1);

        // Abort mid-write: outputs must clear without waiting for a clock edge
        clear_faults();
        @(negedge clk);
        wcount = 0;
        rcount = 0;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(bus.mem_wr && bus.mem_add == 3'd4) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("reached_addr4", 32'({bus.mem_wr, bus.mem_add}), 32'h0000_000C);
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (LAT + 4) @(negedge clk);
        run_one(1'b0);

        clear_faults();
        set_sa(6, 7, 1'b1);
        run_one(1'b0);

        for (int t = 0; t < 20; t++) begin
            clear_faults();
            nf = $urandom_range(0, 3);
            for (int f = 0; f < nf; f++) begin
                a = $urandom_range(0, DEPTH - 1);
                b = $urandom_range(0, 7);
                set_sa(a, b, 1'($urandom_range(0, 1)));
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_one(1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach the summary in time");
        $fatal(1);
    end
endmodule

// File: doc/sram_bist_ctrl.md
Name: sram_bist_ctrl

Overview:
- Initiator-side controller for the 8x8 synchronous SRAM port (wr, rd, add, data_in -> data_out).
- On a start pulse it writes a known pattern to every address, reads each address back and compares the result against the expected value.
- Reports done, pass/fail, first failing address and error count.
- Sits between system control logic and the SRAM instance as its built-in self-test master.

Parameters:
- DATA_W, 8, SRAM word width.
- ADDR_W, 3, SRAM address width; DEPTH = 2**ADDR_W.
- RD_LAT, 1, cycles from the clk edge sampling mem_rd=1 to valid mem_data_out; legal range 1..4.
- SEED, 8'hAA, pattern base; pattern(a) = (SEED + a) mod 2**DATA_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  one-cycle request to run the test; sampled in IDLE only.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse at end of test.
- pass  output  1  result; valid from done, held until the next accepted start.
- fail_addr  output  ADDR_W  address of first mismatch; 0 if none.
- err_cnt  output  ADDR_W+2  number of mismatches, saturating.
- mem_wr  output  1  to SRAM wr.
- mem_rd  output  1  to SRAM rd.
- mem_add  output  ADDR_W  to SRAM add.
- mem_data_in  output  DATA_W  to SRAM data_in.
- mem_data_out  input  DATA_W  from SRAM data_out.

Behaviour:
- Reset (asynchronous, immediate): state IDLE. All outputs are 0. The compare pipeline is cleared.
- FSM states: IDLE, WRITE, READ, DRAIN, DONE. All outputs are registered.
- IDLE:
  - start=1 -> WRITE with addr=0.
  - err_cnt, fail_addr and pass are cleared on acceptance.
  - busy=1 from the next cycle.
- WRITE:
  - One address per cycle: mem_wr=1, mem_add=addr, mem_data_in=pattern(addr).
  - After addr=DEPTH-1 -> READ with addr=0.
- READ:
  - One address per cycle: mem_rd=1, mem_add=addr.
  - {addr, pattern(addr)} is pushed into an RD_LAT-deep expected pipeline.
  - After addr=DEPTH-1 -> DRAIN.
- Compare: when a pipeline entry matures, mem_data_out is compared with the expected value.
  - On mismatch, err_cnt increments, saturating at all-ones.
  - fail_addr latches only on the first mismatch of a run.
- DRAIN: no memory access; hold for RD_LAT cycles until the pipeline is empty, then -> DONE.
- DONE:
  - done=1 for one cycle, busy=0.
  - pass=1 iff err_cnt==0; pass holds after done.
  - -> IDLE.
- Latency: the done pulse occurs 2*DEPTH+RD_LAT+1 cycles after the edge sampling start. The default is 18.
- mem_wr and mem_rd are never high in the same cycle. Both are 0 in IDLE, DRAIN and DONE.
- mem_add and mem_data_in hold their last value when not accessing. The value is don't-care to the SRAM.
- start while busy=1 or in DONE: ignored, no restart.
- Address counter wraps only at phase change; it never wraps within a phase.
- Reset mid-run: abort at once, all outputs 0. No done pulse. A new start is required.

Optional Feature:
- Macro: SRAM_BIST_MARCH_EN.
- Defined: after the READ phase, two extra phases run.
  - WRITE_INV writes ~pattern(a) to all addresses.
  - READ_INV reads them back, comparing against ~pattern(a).
  - The pipeline for the last READ compares overlaps WRITE_INV; writes must not disturb matured compares.
  - DRAIN follows READ_INV. Done latency = 4*DEPTH+RD_LAT+1 (default 34).
- Undefined: only WRITE/READ phases exist; the inverse states and logic are absent.

Test Plan:
- Fault-free SRAM model, RD_LAT=1, start pulse:
  - Writes AA..B1 to addresses 0..7, then reads 0..7.
  - done at cycle 18, pass=1, err_cnt=0, fail_addr=0.
- SRAM model with bit0 stuck-at-0 at address 3 (expected AD, reads AC):
  - pass=0, err_cnt=1, fail_addr=3.
- Stuck-at faults at addresses 5 and 2:
  - fail_addr=2 (first read mismatch), err_cnt=2.
- Second start pulse at cycle 4 while busy:
  - Ignored; single done at cycle 18.
  - mem_wr never overlaps mem_rd (assert every cycle).
- rst pulsed during WRITE phase at addr 4:
  - All outputs 0 immediately, no done.
  - A following start completes normally with pass=1.
- SRAM_BIST_MARCH_EN defined, fault-free:
  - Write phase 2 puts 55 at address 0; done at cycle 34, pass=1.
  - With addr 6 bit7 stuck-at-1: err_cnt=1 (inverse phase only), fail_addr=6.
